// File: rtl/ro_monitor_pkg.sv
// rtl/ro_monitor_pkg.sv - shared FSM encodings for the ring-oscillator drift monitor
package ro_monitor_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CALIB   = 2'd1;
   localparam logic [1:0] ST_MONITOR = 2'd2;
   localparam logic [1:0] ST_ALARM   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_CALIB   = ST_CALIB,
      S_MONITOR = ST_MONITOR,
      S_ALARM   = ST_ALARM
   } state_t;

endpackage

// File: rtl/ro_drift_monitor_if.sv
// rtl/ro_drift_monitor_if.sv - sample-in / deviation-out bundle for ro_drift_monitor
interface ro_sample_if #(parameter int WIDTH = 20);

   logic [WIDTH-1:0] count_in;
   logic             valid_in;
   logic [WIDTH-1:0] threshold;
   logic [WIDTH-1:0] deviation;
   logic             dev_valid;

   modport master (output count_in, valid_in, threshold, input deviation, dev_valid);
   modport slave  (input count_in, valid_in, threshold, output deviation, dev_valid);

endinterface

// File: rtl/ro_abs_diff.sv
// rtl/ro_abs_diff.sv - unsigned |a - b| with strict over-threshold flag
module ro_abs_diff #(
   parameter int WIDTH = 20
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] threshold,
   output logic [WIDTH-1:0] diff,
   output logic             hit
);

   assign diff = (a >= b) ? (a - b) : (b - a);
   assign hit  = diff > threshold;

endmodule

// File: rtl/ro_drift_monitor.sv
// rtl/ro_drift_monitor.sv - calibrates a baseline sensor count, then flags sustained drift
module ro_drift_monitor
   import ro_monitor_pkg::*;
#(
   parameter int WIDTH    = 20,
   parameter int LOG2_CAL = 4,
   parameter int HOLD     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear_alarm,
   ro_sample_if.slave       smp,
   output logic [WIDTH-1:0] baseline,
   output logic             calibrated,
   output logic             alarm,
   output logic [1:0]       state_o
);

   localparam int HW = $clog2(HOLD + 1);

   logic [1:0]                state;
   logic [WIDTH+LOG2_CAL-1:0] acc;
   logic [WIDTH+LOG2_CAL-1:0] acc_next;
   logic [LOG2_CAL-1:0]       n_cal;
   logic [HW-1:0]             hits;
   logic [HW-1:0]             hits_sat;
   logic [WIDTH-1:0]          diff;
   logic                      hit;
   logic                      accept;
   logic                      last_cal;
   logic                      hold_reached;

   ro_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
      .a         (smp.count_in),
      .b         (baseline),
      .threshold (smp.threshold),
      .diff      (diff),
      .hit       (hit)
   );

   assign accept       = en && smp.valid_in && (state != ST_IDLE);
   assign acc_next     = acc + {{LOG2_CAL{1'b0}}, smp.count_in};
   assign last_cal     = (n_cal == '1);
   assign hits_sat     = (32'(hits) >= HOLD) ? hits : hits + HW'(1);
   assign hold_reached = (32'(hits) + 1) >= HOLD;
   assign state_o      = state;

   // en low behaves exactly like reset so an aborted calibration leaves no residue
   always_ff @(posedge clk) begin
      if (!rst || !en) begin
         state         <= ST_IDLE;
         acc           <= '0;
         n_cal         <= '0;
         hits          <= '0;
         baseline      <= '0;
         calibrated    <= 1'b0;
         alarm         <= 1'b0;
         smp.deviation <= '0;
         smp.dev_valid <= 1'b0;
      end else begin
         smp.dev_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               state <= ST_CALIB;
               acc   <= '0;
               n_cal <= '0;
            end
            ST_CALIB: begin
               if (accept) begin
                  acc   <= acc_next;
                  n_cal <= n_cal + LOG2_CAL'(1);
                  if (last_cal) begin
                     baseline   <= acc_next[WIDTH+LOG2_CAL-1:LOG2_CAL];
                     calibrated <= 1'b1;
                     state      <= ST_MONITOR;
                  end
               end
            end
            default: begin
               if (accept) begin
                  smp.deviation <= diff;
                  smp.dev_valid <= 1'b1;
                  hits          <= hit ? hits_sat : '0;
               end
               // an acknowledge wins over a simultaneous hit
               if (state == ST_ALARM && clear_alarm) begin
                  alarm <= 1'b0;
                  hits  <= '0;
                  state <= ST_MONITOR;
               end else if (state == ST_MONITOR && accept && hit && hold_reached) begin
                  alarm <= 1'b1;
                  state <= ST_ALARM;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/ro_drift_monitor.md
RO_DRIFT_MONITOR -- requirements
Module: ro_drift_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 20, meaning sensor-sum width, equal to the upstream sensor_adder WIDTH.
REQ-002 SHALL have parameter LOG2_CAL, default 4, meaning log2 of the calibration sample count (16 samples).
REQ-003 SHALL have parameter HOLD, default 3, meaning consecutive over-threshold samples needed to raise alarm.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 en  input  1  block enable, shared with the sensor array.
REQ-008 count_in  input  WIDTH  summed sensor count from sensor_adder.count.
REQ-009 valid_in  input  1  one-cycle qualifier for count_in, from sensor_adder.valid_out.
REQ-010 threshold  input  WIDTH  deviation limit; sampled on each accepted sample.
REQ-011 clear_alarm  input  1  one-cycle alarm acknowledge.
REQ-012 baseline  output  WIDTH  calibrated mean count.
REQ-013 deviation  output  WIDTH  |count_in - baseline| of the last monitored sample.
REQ-014 dev_valid  output  1  one-cycle pulse qualifying deviation.
REQ-015 calibrated  output  1  high once baseline is valid.
REQ-016 alarm  output  1  sticky drift alarm.
REQ-017 state_o  output  2  current FSM state (IDLE=0, CALIB=1, MONITOR=2, ALARM=3).

Function
REQ-018 A sample SHALL be accepted only when en=1 and valid_in=1 in state CALIB, MONITOR or ALARM; in IDLE valid_in is ignored.
REQ-019 IDLE SHALL go to CALIB on the cycle after en=1; the accumulator and sample counter are 0 on entry to CALIB.
REQ-020 In CALIB each accepted sample SHALL be added to a (WIDTH+LOG2_CAL)-bit accumulator (no overflow possible) and increment the sample counter.
REQ-021 On the 2^LOG2_CAL-th accepted sample, baseline SHALL load floor(sum/2^LOG2_CAL), calibrated SHALL go 1, and the state SHALL be MONITOR, all on the next edge.
REQ-022 In MONITOR and ALARM each accepted sample SHALL register deviation = |count_in - baseline| (unsigned, WIDTH bits) with dev_valid=1 on the next cycle; latency 1 cycle; dev_valid is 0 otherwise.
REQ-023 A sample is a hit when deviation > threshold (strict); equal is not a hit.
REQ-024 A hit counter SHALL increment on each hit, saturate at HOLD, and clear to 0 on any accepted non-hit sample.
REQ-025 When the HOLD-th consecutive hit is accepted in MONITOR, alarm SHALL be 1 and the state ALARM in the same cycle that its dev_valid is 1.
REQ-026 In ALARM alarm SHALL stay 1 and deviation SHALL keep updating until clear_alarm=1, then alarm=0, hit counter=0, state MONITOR on the next edge; baseline retained.
REQ-027 clear_alarm together with an accepted hit SHALL clear; the clear wins, that sample's deviation is still reported, and the hit counter becomes 0.
REQ-028 clear_alarm outside ALARM SHALL be ignored.
REQ-029 en=0 in any state SHALL force IDLE on the next edge with all outputs at reset values; a partial calibration is discarded.

Reset
REQ-030 rst=0 at a clock edge SHALL set state IDLE and baseline, deviation, dev_valid, calibrated, alarm, accumulator, sample counter and hit counter to 0.
REQ-031 rst SHALL take priority over en, valid_in and clear_alarm.

Structure
REQ-032 A shared package ro_monitor_pkg SHALL hold the FSM state enum typedef and the state encodings.
REQ-033 The absolute-difference and compare logic SHALL be one combinational sub-module, ro_abs_diff (inputs a, b, threshold; outputs diff, hit).

Verification
REQ-034 Reset: hold rst=0 for 2 cycles with en=1 and valid_in=1 -> all outputs 0 and state_o=0.
REQ-035 Calibration: en=1, then 16 samples of 1000..1015 (sum 16120) -> baseline=1007 and calibrated=1 one cycle after the 16th sample.
REQ-036 Alarm: baseline=1000, threshold=50, samples 1040,1060,1070,1080 -> deviation 40,60,70,80; alarm=1 together with the dev_valid for 1080; a sample of 950 (deviation 50) is not a hit.
REQ-037 Non-consecutive: samples 1060,1070,1010,1060,900 -> no alarm; deviation of 900 is 100.
REQ-038 Clear: in ALARM, clear_alarm together with hit sample 1100 -> deviation 100 reported, alarm=0 and state MONITOR next cycle, 3 fresh hits needed to re-alarm.
REQ-039 Abort: en dropped after 7 calibration samples -> IDLE next cycle; after en=1 again, calibrated rises only after 16 new samples.
